// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: once per video frame, advances the ball position by the
// programmed velocity, bounces it off the screen edges and pushes X/Y to the
// display block as two bus writes (address 3, then address 4).
// Optional build macro BALL_MOTION_GRAVITY_EN adds a per-frame VY increment.
module ball_motion_ctrl #(
  parameter int unsigned X_MAX   = 1152,
  parameter int unsigned Y_MAX   = 416,
  parameter int unsigned X_RESET = 100,
  parameter int unsigned Y_RESET = 100,
  parameter int unsigned GRAVITY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_write,
  input  logic [2:0]  cfg_address,
  input  logic [15:0] cfg_writedata,
  output logic [15:0] cfg_readdata,
  input  logic        vs_n,
  output logic        m_chipselect,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [15:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, WR_X, WR_Y} state_t;

  localparam logic signed [12:0] X_LIM = 13'(X_MAX);
  localparam logic signed [12:0] Y_LIM = 13'(Y_MAX);

  state_t            state;
  logic signed [7:0] vx, vy, vx_nxt, vy_nxt;
  logic [10:0]       x, x_nxt;
  logic [9:0]        y, y_nxt;
  logic              run, ovr, push, vs_q, tick;
  logic signed [12:0] sx, sy;
  logic              unused_bits;
`ifdef BALL_MOTION_GRAVITY_EN
  logic signed [8:0] vy_g;
`endif

  assign unused_bits = ^{cfg_writedata[15:11], 32'(GRAVITY)};
  assign tick        = vs_q & ~vs_n;
  assign busy        = (state != IDLE);

  function automatic logic signed [7:0] neg_sat(input logic signed [7:0] v);
    return (v == 8'sh80) ? 8'sd127 : -v;
  endfunction

  // Frame tick detection: remember the previous VS level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vs_q <= 1'b1;
    else          vs_q <= vs_n;
  end

  // Next position/velocity: bounce arithmetic in CALC, then cfg writes override.
  always_comb begin
    x_nxt  = x;
    y_nxt  = y;
    vx_nxt = vx;
    vy_nxt = vy;
    sx     = $signed({2'b00, x}) + 13'(vx);
    sy     = $signed({3'b000, y}) + 13'(vy);
`ifdef BALL_MOTION_GRAVITY_EN
    vy_g   = '0;
`endif
    if (state == CALC) begin
      if (sx < 0) begin
        x_nxt  = '0;
        vx_nxt = neg_sat(vx);
      end else if (sx > X_LIM) begin
        x_nxt  = 11'(X_MAX);
        vx_nxt = neg_sat(vx);
      end else begin
        x_nxt  = sx[10:0];
      end
      if (sy < 0) begin
        y_nxt  = '0;
        vy_nxt = neg_sat(vy);
      end else if (sy > Y_LIM) begin
        y_nxt  = 10'(Y_MAX);
        vy_nxt = neg_sat(vy);
      end else begin
        y_nxt  = sy[9:0];
      end
`ifdef BALL_MOTION_GRAVITY_EN
      vy_g   = $signed({vy_nxt[7], vy_nxt}) + $signed({1'b0, 8'(GRAVITY)});
      vy_nxt = (vy_g > 9'sd127) ? 8'sd127 : vy_g[7:0];
`endif
    end
    if (cfg_write) begin
      case (cfg_address)
        3'd0:    vx_nxt = cfg_writedata[7:0];
        3'd1:    vy_nxt = cfg_writedata[7:0];
        3'd2:    x_nxt  = cfg_writedata[10:0];
        3'd3:    y_nxt  = cfg_writedata[9:0];
        default: ;
      endcase
    end
  end

  // Slave read mux.
  always_comb begin
    case (cfg_address)
      3'd0:    cfg_readdata = {{8{vx[7]}}, vx};
      3'd1:    cfg_readdata = {{8{vy[7]}}, vy};
      3'd2:    cfg_readdata = {5'b0, x};
      3'd3:    cfg_readdata = {6'b0, y};
      3'd4:    cfg_readdata = {13'b0, ovr, busy, run};
      default: cfg_readdata = '0;
    endcase
  end

  // Control registers, sequencing FSM and registered master outputs.
  // Write data is loaded from the next-value nets so it matches what X/Y hold
  // while the write is driven, and stays frozen during a stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x            <= 11'(X_RESET);
      y            <= 10'(Y_RESET);
      vx           <= '0;
      vy           <= '0;
      run          <= 1'b0;
      ovr          <= 1'b0;
      push         <= 1'b0;
      state        <= IDLE;
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      m_address    <= '0;
      m_writedata  <= '0;
    end else begin
      x  <= x_nxt;
      y  <= y_nxt;
      vx <= vx_nxt;
      vy <= vy_nxt;
      if (cfg_write && cfg_address == 3'd4) begin
        run <= cfg_writedata[0];
        if (cfg_writedata[1]) ovr <= 1'b0;
      end
      if (tick && state != IDLE) ovr <= 1'b1;
      if (state == WR_Y && !m_waitrequest) push <= 1'b0;
      if (cfg_write && (cfg_address == 3'd2 || cfg_address == 3'd3)) push <= 1'b1;
      case (state)
        IDLE: begin
          if (tick && run) begin
            state <= CALC;
          end else if (tick && push) begin
            state        <= WR_X;
            m_chipselect <= 1'b1;
            m_write      <= 1'b1;
            m_address    <= 3'd3;
            m_writedata  <= {5'b0, x_nxt};
          end
        end
        CALC: begin
          state        <= WR_X;
          m_chipselect <= 1'b1;
          m_write      <= 1'b1;
          m_address    <= 3'd3;
          m_writedata  <= {5'b0, x_nxt};
        end
        WR_X: begin
          if (!m_waitrequest) begin
            state       <= WR_Y;
            m_address   <= 3'd4;
            m_writedata <= {6'b0, y_nxt};
          end
        end
        WR_Y: begin
          if (!m_waitrequest) begin
            state        <= IDLE;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            m_address    <= '0;
            m_writedata  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
